// File: rtl/branch_pred_gshare.sv
// Fetch-stage branch predictor: set-associative BTB with round-robin replacement
// plus a gshare PHT of 2-bit counters indexed by PC xor speculative global history.
module branch_pred_gshare #(
   parameter int ADDR_WIDTH    = 64,
   parameter int BTB_SET_COUNT = 8,
   parameter int BTB_WAYS      = 4,
   parameter int PHT_ENTRIES   = 256,
   parameter int GHR_WIDTH     = 8
) (
   input  logic                        i_clk,
   input  logic                        i_arst,
   input  logic                        i_stall_fetch,
   input  logic [ADDR_WIDTH-1:0]       i_pc,
   input  logic                        i_upd_valid,
   input  logic                        i_upd_taken,
   input  logic                        i_upd_mispredict,
   input  logic [ADDR_WIDTH-1:0]       i_upd_pc,
   input  logic [ADDR_WIDTH-1:0]       i_upd_target,
   input  logic [GHR_WIDTH-1:0]        i_upd_ghr,
   input  logic                        i_upd_btb_hit,
   input  logic [$clog2(BTB_WAYS)-1:0] i_upd_way,
   output logic                        o_pred_taken,
   output logic                        o_pred_hit,
   output logic [$clog2(BTB_WAYS)-1:0] o_pred_way,
   output logic [ADDR_WIDTH-1:0]       o_pred_target,
   output logic [GHR_WIDTH-1:0]        o_pred_ghr
);

   localparam int SET_BITS = $clog2(BTB_SET_COUNT);
   localparam int WAY_BITS = $clog2(BTB_WAYS);
   localparam int PHT_BITS = $clog2(PHT_ENTRIES);
   localparam int TAG_BITS = ADDR_WIDTH - 2 - SET_BITS;

   typedef logic [TAG_BITS-1:0]   tag_t;
   typedef logic [SET_BITS-1:0]   set_t;
   typedef logic [WAY_BITS-1:0]   way_t;
   typedef logic [PHT_BITS-1:0]   pht_idx_t;
   typedef logic [GHR_WIDTH-1:0]  ghr_t;
   typedef logic [ADDR_WIDTH-1:0] addr_t;

   logic [BTB_WAYS-1:0] valid_q  [BTB_SET_COUNT];
   logic [BTB_WAYS-1:0] valid_d  [BTB_SET_COUNT];
   tag_t                tag_q    [BTB_SET_COUNT][BTB_WAYS];
   tag_t                tag_d    [BTB_SET_COUNT][BTB_WAYS];
   addr_t               target_q [BTB_SET_COUNT][BTB_WAYS];
   addr_t               target_d [BTB_SET_COUNT][BTB_WAYS];
   way_t                rr_q     [BTB_SET_COUNT];
   way_t                rr_d     [BTB_SET_COUNT];
   logic [1:0]          pht_q    [PHT_ENTRIES];
   logic [1:0]          pht_d    [PHT_ENTRIES];
   ghr_t                ghr_q;
   ghr_t                ghr_d;

   set_t     f_set;
   tag_t     f_tag;
   pht_idx_t f_pht_idx;
   set_t     u_set;
   tag_t     u_tag;
   pht_idx_t u_pht_idx;

   logic       pred_hit;
   logic       pred_taken;
   way_t       pred_way;
   addr_t      pred_target;
   logic       alloc_found;
   way_t       alloc_way;
   logic [1:0] u_ctr;

   // The two low PC bits are the byte offset and never participate.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{i_pc[1:0], i_upd_pc[1:0]};

   assign f_set     = i_pc[2 +: SET_BITS];
   assign f_tag     = i_pc[ADDR_WIDTH-1 -: TAG_BITS];
   assign f_pht_idx = i_pc[2 +: PHT_BITS] ^ pht_idx_t'(ghr_q);
   assign u_set     = i_upd_pc[2 +: SET_BITS];
   assign u_tag     = i_upd_pc[ADDR_WIDTH-1 -: TAG_BITS];
   assign u_pht_idx = i_upd_pc[2 +: PHT_BITS] ^ pht_idx_t'(i_upd_ghr);
   assign u_ctr     = pht_q[u_pht_idx];

   always_comb begin
      pred_hit    = 1'b0;
      pred_way    = '0;
      pred_target = '0;
      for (int w = 0; w < BTB_WAYS; w++) begin
         if (valid_q[f_set][w] && (tag_q[f_set][w] == f_tag)) begin
            pred_hit    = 1'b1;
            pred_way    = way_t'(w);
            pred_target = target_q[f_set][w];
         end
      end
   end

   assign pred_taken = pred_hit & pht_q[f_pht_idx][1];

   // Lowest-index invalid way wins; round-robin victim only when the set is full.
   always_comb begin
      alloc_found = 1'b0;
      alloc_way   = rr_q[u_set];
      for (int w = 0; w < BTB_WAYS; w++) begin
         if (!valid_q[u_set][w] && !alloc_found) begin
            alloc_found = 1'b1;
            alloc_way   = way_t'(w);
         end
      end
   end

   always_comb begin
      ghr_d = ghr_q;
      if (i_upd_valid && i_upd_mispredict) begin
         ghr_d = ghr_t'({i_upd_ghr, i_upd_taken});
      end else if (!i_stall_fetch && pred_hit) begin
         ghr_d = ghr_t'({ghr_q, pred_taken});
      end
   end

   always_comb begin
      pht_d = pht_q;
      if (i_upd_valid) begin
         if (i_upd_taken) begin
            if (u_ctr != 2'b11) pht_d[u_pht_idx] = u_ctr + 2'd1;
         end else begin
            if (u_ctr != 2'b00) pht_d[u_pht_idx] = u_ctr - 2'd1;
         end
      end
   end

   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      rr_d     = rr_q;
      if (i_upd_valid && i_upd_taken) begin
         if (i_upd_btb_hit) begin
            target_d[u_set][i_upd_way] = i_upd_target;
         end else begin
            valid_d[u_set][alloc_way]  = 1'b1;
            tag_d[u_set][alloc_way]    = u_tag;
            target_d[u_set][alloc_way] = i_upd_target;
            if (!alloc_found) rr_d[u_set] = rr_q[u_set] + way_t'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_arst) begin
         ghr_q <= '0;
         for (int s = 0; s < BTB_SET_COUNT; s++) begin
            valid_q[s] <= '0;
            rr_q[s]    <= '0;
         end
         for (int i = 0; i < PHT_ENTRIES; i++) begin
            pht_q[i] <= 2'b01;
         end
      end else begin
         ghr_q   <= ghr_d;
         valid_q <= valid_d;
         rr_q    <= rr_d;
         pht_q   <= pht_d;
      end
   end

   // Tags and targets are qualified by valid bits, so they need no reset.
   always_ff @(posedge i_clk) begin
      tag_q    <= tag_d;
      target_q <= target_d;
   end

   assign o_pred_hit    = pred_hit;
   assign o_pred_taken  = pred_taken;
   assign o_pred_way    = pred_way;
   assign o_pred_target = pred_target;
   assign o_pred_ghr    = ghr_q;

endmodule

// File: tb/tb_branch_pred_gshare.sv
// Scoreboard bench for branch_pred_gshare: directed scenarios then random traffic,
// checked against an arithmetic reference model of BTB, PHT and GHR.
module tb_branch_pred_gshare;

   localparam int SETS   = 8;
   localparam int WAYS   = 4;
   localparam int PHT    = 256;
   localparam int GHRN   = 256;
   localparam int SETSH  = 5;

   bit          i_clk = 1'b0;
   logic        i_arst, i_stall_fetch, i_upd_valid, i_upd_taken, i_upd_mispredict, i_upd_btb_hit;
   logic [63:0] i_pc, i_upd_pc, i_upd_target;
   logic [7:0]  i_upd_ghr;
   logic [1:0]  i_upd_way;
   logic        o_pred_taken, o_pred_hit;
   logic [1:0]  o_pred_way;
   logic [63:0] o_pred_target;
   logic [7:0]  o_pred_ghr;

   branch_pred_gshare dut (
      .i_clk(i_clk), .i_arst(i_arst), .i_stall_fetch(i_stall_fetch), .i_pc(i_pc),
      .i_upd_valid(i_upd_valid), .i_upd_taken(i_upd_taken), .i_upd_mispredict(i_upd_mispredict),
      .i_upd_pc(i_upd_pc), .i_upd_target(i_upd_target), .i_upd_ghr(i_upd_ghr),
      .i_upd_btb_hit(i_upd_btb_hit), .i_upd_way(i_upd_way),
      .o_pred_taken(o_pred_taken), .o_pred_hit(o_pred_hit), .o_pred_way(o_pred_way),
      .o_pred_target(o_pred_target), .o_pred_ghr(o_pred_ghr)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [63:0] pc;
      logic        hit;
      logic [1:0]  way;
      logic [63:0] tgt;
      logic        taken;
      logic [7:0]  ghr;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_txn   = 0;
   bit   tb_end  = 1'b0;
   bit   drained = 1'b0;

   // Reference model state
   bit          m_known = 1'b0;
   bit          m_valid [SETS][WAYS];
   logic [63:0] m_tag   [SETS][WAYS];
   logic [63:0] m_tgt   [SETS][WAYS];
   int          m_rr    [SETS];
   int          m_pht   [PHT];
   int          m_ghr;

   function automatic int m_set(input logic [63:0] pc);
      return int'((pc >> 2) % 64'(SETS));
   endfunction

   function automatic int m_pidx(input logic [63:0] pc, input int ghr);
      return int'((pc >> 2) % 64'(PHT)) ^ ghr;
   endfunction

   task automatic m_reset();
      for (int s = 0; s < SETS; s++) begin
         m_rr[s] = 0;
         for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
      end
      for (int i = 0; i < PHT; i++) m_pht[i] = 1;
      m_ghr = 0;
   endtask

   task automatic m_lookup(input logic [63:0] pc, output bit hit, output int way, output logic [63:0] tgt);
      int s;
      s = m_set(pc);
      hit = 1'b0; way = 0; tgt = '0;
      for (int w = 0; w < WAYS; w++)
         if (m_valid[s][w] && m_tag[s][w] == (pc >> SETSH)) begin
            hit = 1'b1; way = w; tgt = m_tgt[s][w];
         end
   endtask

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge i_clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         n_txn++;
         $display("[TB] txn %0d pc=%h hit=%0d way=%0d tgt=%h taken=%0d ghr=%h", n_txn, e.pc,
                  o_pred_hit, o_pred_way, o_pred_target, o_pred_taken, o_pred_ghr);
         cmp("pred_hit", 64'(o_pred_hit), 64'(e.hit));
         cmp("pred_way", 64'(o_pred_way), 64'(e.way));
         cmp("pred_target", o_pred_target, e.tgt);
         cmp("pred_taken", 64'(o_pred_taken), 64'(e.taken));
         cmp("pred_ghr", 64'(o_pred_ghr), 64'(e.ghr));
      end else if (tb_end && !drained) begin
         cmp("scoreboard_drain", 64'(sb_q.size()), 64'd0);
         drained = 1'b1;
      end
   end

   // One clock of stimulus: expectation from the pre-edge model, then model update.
   task automatic drive(input logic arst, input logic [63:0] pc, input logic stall,
                        input logic uv, input logic ut, input logic um,
                        input logic [63:0] upc, input logic [63:0] utgt,
                        input logic [7:0] ughr, input logic ubh, input logic [1:0] uway);
      exp_t e;
      bit   hit;
      int   way, s, w;
      logic [63:0] tgt;
      bit   taken;
      bit   found;
      i_arst = arst; i_pc = pc; i_stall_fetch = stall;
      i_upd_valid = uv; i_upd_taken = ut; i_upd_mispredict = um;
      i_upd_pc = upc; i_upd_target = utgt; i_upd_ghr = ughr;
      i_upd_btb_hit = ubh; i_upd_way = uway;
      m_lookup(pc, hit, way, tgt);
      taken = hit && (m_pht[m_pidx(pc, m_ghr)] >= 2);
      if (m_known) begin
         e.pc = pc; e.hit = hit; e.way = 2'(way); e.tgt = tgt; e.taken = taken; e.ghr = 8'(m_ghr);
         sb_q.push_back(e);
      end
      @(posedge i_clk);
      if (arst) begin
         m_reset();
         m_known = 1'b1;
      end else begin
         if (uv && um) m_ghr = (int'(ughr) * 2 + int'(ut)) % GHRN;
         else if (!stall && hit) m_ghr = (m_ghr * 2 + int'(taken)) % GHRN;
         if (uv) begin
            s = m_pidx(upc, int'(ughr));
            m_pht[s] = ut ? ((m_pht[s] < 3) ? m_pht[s] + 1 : 3) : ((m_pht[s] > 0) ? m_pht[s] - 1 : 0);
         end
         if (uv && ut) begin
            s = m_set(upc);
            if (ubh) begin
               m_tgt[s][int'(uway)] = utgt;
            end else begin
               found = 1'b0; w = 0;
               for (int k = WAYS - 1; k >= 0; k--) if (!m_valid[s][k]) begin found = 1'b1; w = k; end
               if (!found) begin
                  w = m_rr[s];
                  m_rr[s] = (m_rr[s] + 1) % WAYS;
               end
               m_valid[s][w] = 1'b1; m_tag[s][w] = upc >> SETSH; m_tgt[s][w] = utgt;
            end
         end
      end
      #1;
   endtask

   task automatic fetch(input logic [63:0] pc, input logic stall);
      drive(1'b0, pc, stall, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h0, 1'b0, 2'd0);
   endtask

   task automatic upd(input logic [63:0] pc, input logic stall, input logic ut, input logic um,
                      input logic [63:0] upc, input logic [63:0] utgt, input logic [7:0] ughr,
                      input logic ubh, input logic [1:0] uway);
      drive(1'b0, pc, stall, 1'b1, ut, um, upc, utgt, ughr, ubh, uway);
   endtask

   function automatic logic [63:0] rnd_pc();
      logic [63:0] p;
      p = 64'h1000 + 64'(4 * $urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) p[47:40] = 8'($urandom);
      return p;
   endfunction

   initial begin
      logic [63:0] pc, upc, utgt;
      logic        stall, uv, ut, um;
      logic [7:0]  ughr;
      bit          bh;
      int          bw;
      logic [63:0] dummy;

      drive(1'b1, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h0, 1'b0, 2'd0);
      drive(1'b1, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h0, 1'b0, 2'd0);
      fetch(64'h1000, 1'b0);

      // First allocation, read-during-write miss, then hit with stalled and unstalled fetch
      upd(64'h1000, 1'b0, 1'b1, 1'b0, 64'h1000, 64'h2000, 8'h00, 1'b0, 2'd0);
      fetch(64'h1000, 1'b1);
      fetch(64'h1000, 1'b0);
      fetch(64'h2000, 1'b0);

      // Fill set 0 and evict with round robin
      drive(1'b1, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h0, 1'b0, 2'd0);
      for (int k = 0; k < 5; k++)
         upd(64'h3004, 1'b1, 1'b1, 1'b0, 64'h1000 + 64'(k * 32), 64'h5000 + 64'(k * 16), 8'h00, 1'b0, 2'd0);
      fetch(64'h1000, 1'b1);
      fetch(64'h1080, 1'b1);
      fetch(64'h1020, 1'b1);

      // Mispredict restore wins over a same-cycle speculative hit
      upd(64'h1080, 1'b0, 1'b0, 1'b1, 64'h1040, 64'h0, 8'h3C, 1'b0, 2'd0);
      fetch(64'h3004, 1'b0);

      // Counter saturation in both directions
      drive(1'b1, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h0, 1'b0, 2'd0);
      upd(64'h1000, 1'b1, 1'b1, 1'b0, 64'h1000, 64'h2000, 8'h00, 1'b0, 2'd0);
      for (int k = 0; k < 3; k++) upd(64'h1000, 1'b1, 1'b1, 1'b0, 64'h1000, 64'h2000, 8'h00, 1'b1, 2'd0);
      fetch(64'h1000, 1'b1);
      for (int k = 0; k < 4; k++) upd(64'h1000, 1'b1, 1'b0, 1'b0, 64'h1000, 64'h0, 8'h00, 1'b0, 2'd0);
      fetch(64'h1000, 1'b1);
      upd(64'h1000, 1'b1, 1'b0, 1'b0, 64'h1000, 64'h0, 8'h00, 1'b0, 2'd0);
      fetch(64'h1000, 1'b1);

      // Reset overrides a same-cycle update
      drive(1'b1, 64'h1100, 1'b0, 1'b1, 1'b1, 1'b0, 64'h1100, 64'h7000, 8'h0, 1'b0, 2'd0);
      fetch(64'h1100, 1'b0);

      for (int n = 0; n < 500; n++) begin
         pc    = rnd_pc();
         stall = ($urandom_range(0, 3) == 0);
         uv    = 1'($urandom_range(0, 1));
         ut    = 1'($urandom_range(0, 1));
         um    = ($urandom_range(0, 4) == 0);
         upc   = rnd_pc();
         utgt  = {$urandom, $urandom} & ~64'h3;
         m_lookup(upc, bh, bw, dummy);
         ughr  = um ? 8'($urandom) : 8'(m_ghr);
         drive((n == 250) ? 1'b1 : 1'b0, pc, stall, uv, ut, um, upc, utgt, ughr, bh, 2'(bw));
      end

      tb_end = 1'b1;
      for (int i = 0; i < 20 && !drained; i++) @(posedge i_clk);
      if (!drained) begin
         $display("[TB] FAIL monitor_timeout: got not drained expected drained");
         $fatal(1, "monitor did not drain");
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
